seven_segment_scan_reader: RTL and testbench
============================================

# seven_segment_scan_reader

Sequential readback encoder for multiplexed common-anode 7-segment displays: samples the active-low segment bus and active-low digit enables, converts each stable segment pattern back to its 4-bit hex value, and keeps one registered nibble per digit with valid/error flags. It sits on the display side of the segment-decoder path. Typical uses are self-checking of the display driver chain and capture of an external display for test equipment.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits (1..8).
- STABLE_CNT, 3, consecutive identical samples of a digit required before commit (1..15).

- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- sample_en  input  1  sample strobe; seg_n/an_n are only examined in cycles where it is high.
- seg_n  input  7  segment bus, active low, {a,b,c,d,e,f,g}, bit 6 = a.
- an_n  input  NUM_DIGITS  digit enables, active low, bit i = digit i.
- digits  output  4*NUM_DIGITS  committed hex values, digit i in bits [4i+3:4i].
- digit_valid  output  NUM_DIGITS  digit i holds a recognised hex value.
- digit_err  output  NUM_DIGITS  last committed pattern of digit i was unrecognised.
- frame_done  output  1  one-cycle pulse: every digit has committed since the previous pulse.
- enable_conflict  output  1  one-cycle pulse: a sampled an_n had more than one bit low.

## Operation
- Code table for seg_n, abcdefg, active low:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111.
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
  - Blank = 1111111. Any other value is an unrecognised pattern.
- Sample handling, per sample_en cycle:
  - an_n all ones: sample ignored, no state change.
  - an_n with two or more bits low: sample ignored and enable_conflict pulses the next cycle.
  - an_n with exactly one bit low (digit i): the sample is processed for digit i.
- Per-digit state: a candidate pattern (7 bits) and a match counter (4 bits, saturating at STABLE_CNT).
- Processing a sample for digit i:
  - seg_n equals candidate: counter increments, saturating.
  - seg_n differs: candidate loads seg_n and counter loads 1.
- Commit happens when the counter value after update equals STABLE_CNT and the pre-update value did not. Commit actions by pattern:
  - Recognised: digits[i] = code, valid = 1, err = 0.
  - Blank: digits[i] holds, valid = 0, err = 0.
  - Unrecognised: digits[i] holds, valid = 0, err = 1.
- A saturated counter fed further matching samples does not re-commit. A changed pattern restarts the count; the old committed value holds until the new pattern commits.
- With STABLE_CNT = 1, every sample whose pattern differs from the candidate commits immediately.
- Frame tracking: seen mask bit i is set on a commit of digit i. When a commit completes the mask (all ones), frame_done pulses and the mask clears in the same edge. A commit in that same edge for a digit not yet seen counts toward the next frame.

## Timing
- All outputs are registered.
- A commit from the sample taken in cycle n is visible on digits/digit_valid/digit_err in cycle n+1.
- The completing commit and its frame_done pulse appear together in cycle n+1.
- enable_conflict appears in cycle n+1 for a conflicting sample in cycle n.
- Throughput: one sample per cycle. sample_en is allowed high every cycle.
- Reset values (asynchronous, applied immediately on rst_n low):
  - digits = 0, digit_valid = 0, digit_err = 0.
  - frame_done = 0, enable_conflict = 0.
  - Candidates = 1111111 (blank), counters = 0, seen mask = 0.
- Reset asserted mid-count discards the partial count.
- First activity after reset: blank samples count from 1, since the candidate is blank but the counter is 0. STABLE_CNT blank samples commit blank with valid = 0, and that commit sets the seen bit.

## Test plan
- Stable digit: NUM_DIGITS=4, STABLE_CNT=3; three samples of an_n=1110, seg_n=0000110. Required: digits[3:0]=3 and digit_valid[0]=1 only after the third sample, one cycle later.
- Glitch rejection: for digit 1, samples A, A, 8, A, A, A (0001000 / 0000000). Required: commit of 0xA only on the sixth sample; digits[7:4] unchanged before it.
- Full frame: scan digits 0..3 with values 1, 2, E, F, STABLE_CNT samples each, interleaved round-robin. Required: a single frame_done pulse coincident with the last commit; digits = 0xFE21.
- Error/blank: digit 2 given 1010101 three times, then 1111111 three times. Required: digit_err[2]=1 and valid[2]=0 after the first commit; err[2]=0, valid[2]=0 after the second; digits[11:8] held throughout.
- Enable faults: an_n=1111 with sample_en=1 -> no change. an_n=1100 -> enable_conflict single pulse, counters unchanged.
- Reset mid-operation: drop rst_n after two of three matching samples. Required: all outputs 0 immediately; after release, three fresh samples are needed to commit.

Source files
------------

// File: rtl/seven_segment_scan_reader.sv
// Readback encoder for a multiplexed common-anode 7-segment display: debounces each digit's
// active-low segment pattern and converts it back to a hex nibble with valid/error flags.
module seven_segment_scan_reader #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned STABLE_CNT = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sample_en,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    frame_done,
  output logic                    enable_conflict
);

  localparam logic [3:0] StableCnt = 4'(STABLE_CNT);
  localparam logic [6:0] SegBlank  = 7'b1111111;

  logic [6:0]              cand_q [NUM_DIGITS];
  logic [6:0]              cand_d [NUM_DIGITS];
  logic [3:0]              cnt_q  [NUM_DIGITS];
  logic [3:0]              cnt_d  [NUM_DIGITS];
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d, err_q, err_d, seen_q, seen_d;
  logic                    frame_q, frame_d, conflict_q, conflict_d;

  logic [NUM_DIGITS-1:0]   an_act;
  logic                    an_none, an_one;
  logic                    known;
  logic [3:0]              code;

  // Returns {recognised, hex code}; blank and garbage both come back unrecognised.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b0000001: decode = {1'b1, 4'h0};
      7'b1001111: decode = {1'b1, 4'h1};
      7'b0010010: decode = {1'b1, 4'h2};
      7'b0000110: decode = {1'b1, 4'h3};
      7'b1001100: decode = {1'b1, 4'h4};
      7'b0100100: decode = {1'b1, 4'h5};
      7'b0100000: decode = {1'b1, 4'h6};
      7'b0001111: decode = {1'b1, 4'h7};
      7'b0000000: decode = {1'b1, 4'h8};
      7'b0000100: decode = {1'b1, 4'h9};
      7'b0001000: decode = {1'b1, 4'hA};
      7'b1100000: decode = {1'b1, 4'hB};
      7'b0110001: decode = {1'b1, 4'hC};
      7'b1000010: decode = {1'b1, 4'hD};
      7'b0110000: decode = {1'b1, 4'hE};
      7'b0111000: decode = {1'b1, 4'hF};
      default:    decode = 5'b0;
    endcase
  endfunction

  assign an_act  = ~an_n;
  assign an_none = (an_act == '0);
  assign an_one  = !an_none && ((an_act & (an_act - NUM_DIGITS'(1))) == '0);

  always_comb begin
    {known, code} = decode(seg_n);
    digits_d   = digits_q;
    valid_d    = valid_q;
    err_d      = err_q;
    seen_d     = seen_q;
    frame_d    = 1'b0;
    conflict_d = sample_en && !an_none && !an_one;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      cand_d[i] = cand_q[i];
      cnt_d[i]  = cnt_q[i];
      if (sample_en && an_one && an_act[i]) begin
        if (seg_n == cand_q[i]) begin
          if (cnt_q[i] != StableCnt) cnt_d[i] = cnt_q[i] + 4'd1;
        end else begin
          cand_d[i] = seg_n;
          cnt_d[i]  = 4'd1;
        end
        // A changed pattern always restarts at 1, so with StableCnt == 1 it commits at once.
        if (cnt_d[i] == StableCnt && (cnt_q[i] != StableCnt || seg_n != cand_q[i])) begin
          seen_d[i]  = 1'b1;
          valid_d[i] = known;
          err_d[i]   = !known && (seg_n != SegBlank);
          if (known) digits_d[4*i +: 4] = code;
        end
      end
    end
    if (&seen_d) begin
      frame_d = 1'b1;
      seen_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        cand_q[i] <= SegBlank;
        cnt_q[i]  <= 4'd0;
      end
      digits_q   <= '0;
      valid_q    <= '0;
      err_q      <= '0;
      seen_q     <= '0;
      frame_q    <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        cand_q[i] <= cand_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      digits_q   <= digits_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      seen_q     <= seen_d;
      frame_q    <= frame_d;
      conflict_q <= conflict_d;
    end
  end

  assign digits          = digits_q;
  assign digit_valid     = valid_q;
  assign digit_err       = err_q;
  assign frame_done      = frame_q;
  assign enable_conflict = conflict_q;

endmodule

// File: tb/tb_seven_segment_scan_reader.sv
// Directed bench for seven_segment_scan_reader: a run-length display model checked every cycle,
// plus literal expectations for each scenario.
module tb_seven_segment_scan_reader;

  localparam int ND = 4;
  localparam int ST = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sample_en = 1'b0;
  logic [6:0]    seg_n = 7'h7F;
  logic [ND-1:0] an_n = '1;
  logic [4*ND-1:0] digits;
  logic [ND-1:0] digit_valid, digit_err;
  logic          frame_done, enable_conflict;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int fd_seen  = 0;

  seven_segment_scan_reader #(.NUM_DIGITS(ND), .STABLE_CNT(ST)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sample_en       (sample_en),
    .seg_n           (seg_n),
    .an_n            (an_n),
    .digits          (digits),
    .digit_valid     (digit_valid),
    .digit_err       (digit_err),
    .frame_done      (frame_done),
    .enable_conflict (enable_conflict)
  );

  always #5 clk = ~clk;

  // Display font: index is the hex value.
  logic [6:0] font [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                            7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                            7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  // Model: per digit, the last pattern seen and how many times in a row it has been seen.
  logic [6:0] m_last [ND];
  int         m_run  [ND];
  logic [3:0] m_dig  [ND];
  bit         m_val  [ND];
  bit         m_err  [ND];
  bit         m_seen [ND];
  bit         m_fd, m_ec;

  task automatic model_reset();
    for (int i = 0; i < ND; i++) begin
      m_last[i] = 7'h7F; m_run[i] = 0; m_dig[i] = 4'h0;
      m_val[i] = 0; m_err[i] = 0; m_seen[i] = 0;
    end
    m_fd = 0; m_ec = 0;
  endtask

  task automatic model_step();
    int nlow, d, idx, all;
    m_fd = 0; m_ec = 0;
    if (!sample_en) return;
    nlow = $countones(~an_n);
    if (nlow > 1) begin m_ec = 1; return; end
    if (nlow == 0) return;
    d = 0;
    for (int i = 0; i < ND; i++) if (!an_n[i]) d = i;
    if (seg_n == m_last[d]) m_run[d]++;
    else begin m_last[d] = seg_n; m_run[d] = 1; end
    if (m_run[d] != ST) return;
    idx = -1;
    for (int k = 0; k < 16; k++) if (font[k] == seg_n) idx = k;
    if (idx >= 0) begin m_dig[d] = 4'(idx); m_val[d] = 1; m_err[d] = 0; end
    else begin m_val[d] = 0; m_err[d] = (seg_n != 7'h7F); end
    m_seen[d] = 1;
    all = 1;
    for (int i = 0; i < ND; i++) if (!m_seen[i]) all = 0;
    if (all == 1) begin
      m_fd = 1;
      for (int i = 0; i < ND; i++) m_seen[i] = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    logic [4*ND-1:0] ed;
    logic [ND-1:0]   ev, ee;
    for (int i = 0; i < ND; i++) begin
      ed[4*i +: 4] = m_dig[i]; ev[i] = m_val[i]; ee[i] = m_err[i];
    end
    check("model digits", 32'(digits), 32'(ed));
    check("model valid", 32'(digit_valid), 32'(ev));
    check("model err", 32'(digit_err), 32'(ee));
    check("model frame_done", 32'(frame_done), 32'(m_fd));
    check("model enable_conflict", 32'(enable_conflict), 32'(m_ec));
    if (frame_done) fd_seen++;
  end

  // Present one sample for the next edge; returns 1 time unit after that edge.
  task automatic samp(input logic [ND-1:0] an, input logic [6:0] seg);
    sample_en = 1'b1; an_n = an; seg_n = seg;
    @(posedge clk); #1;
    sample_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int fd_base;
    do_reset();
    check("reset digits", 32'(digits), 32'h0);
    check("reset valid", 32'(digit_valid), 32'h0);
    check("reset err", 32'(digit_err), 32'h0);

    // Stable digit 0 = 3
    samp(4'b1110, 7'b0000110);
    samp(4'b1110, 7'b0000110);
    check("stable valid0 early", 32'(digit_valid[0]), 32'h0);
    samp(4'b1110, 7'b0000110);
    check("stable digit0", 32'(digits[3:0]), 32'h3);
    check("stable valid0", 32'(digit_valid[0]), 32'h1);

    // Glitch rejection on digit 1: A A 8 A A A
    samp(4'b1101, 7'b0001000);
    samp(4'b1101, 7'b0001000);
    samp(4'b1101, 7'b0000000);
    samp(4'b1101, 7'b0001000);
    samp(4'b1101, 7'b0001000);
    check("glitch digit1 held", 32'(digits[7:4]), 32'h0);
    check("glitch valid1 held", 32'(digit_valid[1]), 32'h0);
    samp(4'b1101, 7'b0001000);
    check("glitch digit1", 32'(digits[7:4]), 32'hA);
    check("glitch valid1", 32'(digit_valid[1]), 32'h1);

    // Unrecognised then blank on digit 2
    repeat (3) samp(4'b1011, 7'b1010101);
    check("bad err2", 32'(digit_err[2]), 32'h1);
    check("bad valid2", 32'(digit_valid[2]), 32'h0);
    check("bad digit2 held", 32'(digits[11:8]), 32'h0);
    repeat (3) samp(4'b1011, 7'b1111111);
    check("blank err2", 32'(digit_err[2]), 32'h0);
    check("blank valid2", 32'(digit_valid[2]), 32'h0);
    check("blank digit2 held", 32'(digits[11:8]), 32'h0);

    // Enable faults: conflict and idle samples must not advance digit 0's count
    samp(4'b1110, 7'b0001111);
    samp(4'b1110, 7'b0001111);
    samp(4'b1100, 7'b0001111);
    check("conflict pulse", 32'(enable_conflict), 32'h1);
    check("conflict digit0 held", 32'(digits[3:0]), 32'h3);
    samp(4'b1111, 7'b0001111);
    check("conflict single pulse", 32'(enable_conflict), 32'h0);
    check("idle digit0 held", 32'(digits[3:0]), 32'h3);
    samp(4'b1110, 7'b0001111);
    check("after faults digit0", 32'(digits[3:0]), 32'h7);

    // Reset after two of three samples
    samp(4'b1110, 7'b0000100);
    samp(4'b1110, 7'b0000100);
    rst_n = 1'b0;
    #2;
    check("async rst digits", 32'(digits), 32'h0);
    check("async rst valid", 32'(digit_valid), 32'h0);
    check("async rst err", 32'(digit_err), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    samp(4'b1110, 7'b0000100);
    samp(4'b1110, 7'b0000100);
    check("post rst no commit", 32'(digit_valid[0]), 32'h0);
    samp(4'b1110, 7'b0000100);
    check("post rst digit0", 32'(digits[3:0]), 32'h9);

    // Full frame: 1, 2, E, F round-robin
    do_reset();
    fd_base = fd_seen;
    for (int r = 0; r < ST; r++) begin
      samp(4'b1110, font[1]);
      samp(4'b1101, font[2]);
      samp(4'b1011, font[14]);
      if (r == ST - 1) check("frame not early", 32'(frame_done), 32'h0);
      samp(4'b0111, font[15]);
    end
    check("frame pulse", 32'(frame_done), 32'h1);
    check("frame digits", 32'(digits), 32'hFE21);
    check("frame valid", 32'(digit_valid), 32'hF);
    @(posedge clk); #1;
    check("frame pulse width", 32'(frame_done), 32'h0);
    @(negedge clk); #1;
    check("frame pulse count", 32'(fd_seen - fd_base), 32'h1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
